tx_scheduler: RTL and testbench

- Go-back-N transmit scheduler that controls when the single laser transmit path (packet generator plus serial transmitter) is used.
- Shares the path between two requesters: control packets from the main TCP FSM (SYN/ACK/FIN, pure ACK) and windowed data packets.
- Tracks the cumulative-ACK base and the retransmission timeout; on timeout it rewinds the next-sequence pointer to the base.
- Sits between the main FSM and receive-packet outputs on one side and the packet generator and serial transmitter handshakes on the other.

---
 rtl/tx_scheduler.sv | 177 +++++++++++++++++
 tb/tb_tx_scheduler.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_scheduler.sv
// Go-back-N transmit scheduler: arbitrates the single transmit path between control
// packets and windowed data, tracks the cumulative-ACK base and rewinds on timeout.
module tx_scheduler #(
  parameter int unsigned SEQ_W   = 32,
  parameter int unsigned TIMEOUT = 20000000,
  parameter int unsigned TMR_W   = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [SEQ_W-1:0] isn,
  input  logic [SEQ_W-1:0] snmax,
  input  logic [15:0]      window,
  input  logic             ack_valid,
  input  logic [SEQ_W-1:0] ack_num,
  input  logic             ctrl_req,
  input  logic             tx_done,
  output logic             send_valid,
  output logic [SEQ_W-1:0] send_seq,
  output logic             send_is_ctrl,
  output logic             ctrl_grant,
  output logic [SEQ_W-1:0] base,
  output logic [SEQ_W-1:0] next_seq,
  output logic             all_acked,
  output logic [7:0]       retx_count,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_READY   = 2'd1,
    S_LAUNCH  = 2'd2,
    S_WAIT_TX = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [SEQ_W-1:0] base_q, base_d;
  logic [SEQ_W-1:0] next_q, next_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic             pend_q, pend_d;
  logic             send_valid_q, send_valid_d;
  logic [SEQ_W-1:0] send_seq_q, send_seq_d;
  logic             send_is_ctrl_q, send_is_ctrl_d;
  logic             ctrl_grant_q, ctrl_grant_d;
  logic [7:0]       retx_q, retx_d;
  logic             all_acked_q, all_acked_d;

  logic [SEQ_W-1:0] end_seq;
  logic [SEQ_W-1:0] next_eff;
  logic             ack_ok;
  logic             timeout;
  logic             eligible;

  // Next-state, pointer, timer and launch strobe computation
  always_comb begin
    state_d        = state_q;
    base_d         = base_q;
    next_d         = next_q;
    pend_d         = pend_q;
    send_valid_d   = 1'b0;
    send_seq_d     = send_seq_q;
    send_is_ctrl_d = send_is_ctrl_q;
    ctrl_grant_d   = 1'b0;
    retx_d         = retx_q;

    end_seq = isn + snmax;
    ack_ok  = (state_q != S_IDLE) && ack_valid && (ack_num > base_q) && (ack_num <= next_q);
    // An accepted ACK in the same cycle suppresses the timeout entirely
    timeout = (state_q != S_IDLE) && (base_q != next_q) &&
              (timer_q == TMR_W'(TIMEOUT - 1)) && !ack_ok;

    timer_d = (base_q != next_q) ? timer_q + TMR_W'(1) : '0;
    if (timeout) begin
      timer_d = '0;
      if (retx_q != 8'hFF) retx_d = retx_q + 8'd1;
    end

    // Eligibility is judged against the pointer after any same-cycle rewind
    next_eff = (timeout && state_q == S_READY) ? base_q : next_q;
    eligible = enable && (next_eff < end_seq) && ((next_eff - base_q) < SEQ_W'(window));

    case (state_q)
      S_IDLE: begin
        base_d  = isn;
        next_d  = isn;
        timer_d = '0;
        pend_d  = 1'b0;
        if (ctrl_req || enable) state_d = S_READY;
      end
      S_READY: begin
        next_d = next_eff;
        if (ctrl_req) begin
          state_d        = S_LAUNCH;
          send_valid_d   = 1'b1;
          send_seq_d     = next_eff;
          send_is_ctrl_d = 1'b1;
          ctrl_grant_d   = 1'b1;
        end else if (eligible) begin
          state_d        = S_LAUNCH;
          send_valid_d   = 1'b1;
          send_seq_d     = next_eff;
          send_is_ctrl_d = 1'b0;
        end else if (!enable) begin
          state_d = S_IDLE;
        end
      end
      S_LAUNCH: begin
        state_d = S_WAIT_TX;
        if (timeout) begin
          next_d = base_q;
        end else if (!send_is_ctrl_q) begin
          next_d = next_q + SEQ_W'(1);
          if (base_q == next_q) timer_d = '0;
        end
      end
      S_WAIT_TX: begin
        if (tx_done) begin
          state_d = S_READY;
          if (!ack_ok && (pend_q || timeout)) begin
            next_d = base_q;
            pend_d = 1'b0;
          end
        end else if (timeout) begin
          pend_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (ack_ok) begin
      base_d  = ack_num;
      timer_d = '0;
      pend_d  = 1'b0;
    end

    all_acked_d = (base_d == end_seq);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= S_IDLE;
      base_q         <= '0;
      next_q         <= '0;
      timer_q        <= '0;
      pend_q         <= 1'b0;
      send_valid_q   <= 1'b0;
      send_seq_q     <= '0;
      send_is_ctrl_q <= 1'b0;
      ctrl_grant_q   <= 1'b0;
      retx_q         <= '0;
      all_acked_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      base_q         <= base_d;
      next_q         <= next_d;
      timer_q        <= timer_d;
      pend_q         <= pend_d;
      send_valid_q   <= send_valid_d;
      send_seq_q     <= send_seq_d;
      send_is_ctrl_q <= send_is_ctrl_d;
      ctrl_grant_q   <= ctrl_grant_d;
      retx_q         <= retx_d;
      all_acked_q    <= all_acked_d;
    end
  end

  assign send_valid   = send_valid_q;
  assign send_seq     = send_seq_q;
  assign send_is_ctrl = send_is_ctrl_q;
  assign ctrl_grant   = ctrl_grant_q;
  assign base         = base_q;
  assign next_seq     = next_q;
  assign all_acked    = all_acked_q;
  assign retx_count   = retx_q;
  assign state        = state_q;

endmodule

// File: tb/tb_tx_scheduler.sv
// Directed bench for tx_scheduler: scoreboard of expected launches plus point checks
// of pointers, counters and state around ACKs, timeouts and resets.
module tb_tx_scheduler;

  localparam int unsigned SEQ_W   = 32;
  localparam int unsigned TIMEOUT = 100;

  logic             clk = 1'b0;
  logic             reset;
  logic             enable;
  logic [SEQ_W-1:0] isn;
  logic [SEQ_W-1:0] snmax;
  logic [15:0]      window;
  logic             ack_valid;
  logic [SEQ_W-1:0] ack_num;
  logic             ctrl_req;
  logic             tx_done;
  logic             send_valid;
  logic [SEQ_W-1:0] send_seq;
  logic             send_is_ctrl;
  logic             ctrl_grant;
  logic [SEQ_W-1:0] base;
  logic [SEQ_W-1:0] next_seq;
  logic             all_acked;
  logic [7:0]       retx_count;
  logic [1:0]       state;

  typedef struct packed {
    logic [31:0] seq;
    logic        ctrl;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks  = 0;
  int   errors  = 0;
  int   n_sends = 0;
  int   cyc     = 0;
  int   t0;

  tx_scheduler #(.SEQ_W(SEQ_W), .TIMEOUT(TIMEOUT), .TMR_W(32)) dut (
    .clk(clk), .reset(reset), .enable(enable), .isn(isn), .snmax(snmax),
    .window(window), .ack_valid(ack_valid), .ack_num(ack_num), .ctrl_req(ctrl_req),
    .tx_done(tx_done), .send_valid(send_valid), .send_seq(send_seq),
    .send_is_ctrl(send_is_ctrl), .ctrl_grant(ctrl_grant), .base(base),
    .next_seq(next_seq), .all_acked(all_acked), .retx_count(retx_count), .state(state)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [31:0] seq, input logic ctrl);
    exp_t e;
    e.seq  = seq;
    e.ctrl = ctrl;
    sb.push_back(e);
  endtask

  // Every launch is popped from the scoreboard and compared
  always @(negedge clk) begin
    if (!reset && send_valid) begin
      n_sends++;
      checks++;
      assert (sb.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_send: observed seq=%0h expected no launch", send_seq);
      end
      if (sb.size() != 0) begin
        mon_e = sb.pop_front();
        chk("send_seq", send_seq, mon_e.seq);
        chk("send_is_ctrl", 32'(send_is_ctrl), 32'(mon_e.ctrl));
        chk("ctrl_grant", 32'(ctrl_grant), 32'(mon_e.ctrl));
      end
    end
  end

  task automatic wait_send(input int max);
    int n;
    n = 0;
    @(negedge clk);
    while (!send_valid && n < max) begin
      @(negedge clk);
      n++;
    end
    chk("send_arrived", 32'(send_valid), 32'd1);
  endtask

  task automatic do_tx(input int d);
    repeat (d) @(posedge clk);
    #1 tx_done = 1'b1;
    @(posedge clk);
    #1 tx_done = 1'b0;
  endtask

  task automatic pulse_ack(input logic [31:0] num);
    @(posedge clk);
    #1 ack_valid = 1'b1;
    ack_num = num;
    @(posedge clk);
    #1 ack_valid = 1'b0;
  endtask

  task automatic check_reset_vals();
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_base", base, 32'd0);
    chk("rst_next_seq", next_seq, 32'd0);
    chk("rst_send_valid", 32'(send_valid), 32'd0);
    chk("rst_send_seq", send_seq, 32'd0);
    chk("rst_send_is_ctrl", 32'(send_is_ctrl), 32'd0);
    chk("rst_ctrl_grant", 32'(ctrl_grant), 32'd0);
    chk("rst_retx_count", 32'(retx_count), 32'd0);
    chk("rst_all_acked", 32'(all_acked), 32'd0);
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; isn = '0; snmax = '0; window = '0;
    ack_valid = 1'b0; ack_num = '0; ctrl_req = 1'b0; tx_done = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_vals();

    // Window fill: only seqs 0 and 1 fit in a window of 2
    isn = 32'd0; snmax = 32'd5; window = 16'd2;
    @(posedge clk);
    #1 reset = 1'b0; enable = 1'b1;
    push(32'd0, 1'b0); push(32'd1, 1'b0);
    wait_send(20); do_tx(10);
    wait_send(20); do_tx(10);
    repeat (20) @(negedge clk);
    chk("fill_sends", 32'(n_sends), 32'd2);
    chk("fill_base", base, 32'd0);
    chk("fill_next_seq", next_seq, 32'd2);
    chk("fill_sb_empty", 32'(sb.size()), 32'd0);

    // Cumulative ACKs slide the window to the end
    push(32'd2, 1'b0); push(32'd3, 1'b0);
    pulse_ack(32'd2);
    wait_send(20); do_tx(10);
    wait_send(20); do_tx(10);
    push(32'd4, 1'b0);
    pulse_ack(32'd4);
    wait_send(20); do_tx(10);
    pulse_ack(32'd5);
    @(negedge clk);
    chk("ack_base", base, 32'd5);
    chk("ack_next_seq", next_seq, 32'd5);
    chk("ack_all_acked", 32'(all_acked), 32'd1);
    repeat (10) @(negedge clk);
    chk("ack_total_sends", 32'(n_sends), 32'd5);
    chk("ack_retx_count", 32'(retx_count), 32'd0);

    // Timeout rewind from READY, isn=10
    reset = 1'b1;
    @(posedge clk);
    #1 isn = 32'd10; snmax = 32'd5; window = 16'd2; reset = 1'b0;
    push(32'd10, 1'b0); push(32'd11, 1'b0);
    wait_send(20);
    chk("to_base_isn", base, 32'd10);
    do_tx(10);
    wait_send(20); do_tx(10);
    push(32'd10, 1'b0); push(32'd11, 1'b0);
    wait_send(200);
    chk("to_next_rewound", next_seq, 32'd10);
    chk("to_retx_1", 32'(retx_count), 32'd1);
    pulse_ack(32'd10);
    @(negedge clk);
    chk("dup_ack_ignored", base, 32'd10);
    do_tx(5);
    wait_send(20);

    // Timeout while waiting for tx_done: rewind deferred to tx_done
    repeat (120) @(negedge clk);
    chk("wtx_next_held", next_seq, 32'd12);
    chk("wtx_retx_2", 32'(retx_count), 32'd2);
    chk("wtx_state", 32'(state), 32'd3);
    push(32'd10, 1'b0); push(32'd11, 1'b0);
    do_tx(1);
    @(negedge clk);
    chk("wtx_next_rewound", next_seq, 32'd10);
    chk("wtx_ready", 32'(state), 32'd1);
    wait_send(20);
    do_tx(10);
    wait_send(20);
    do_tx(10);
    chk("wtx_retx_still_2", 32'(retx_count), 32'd2);

    // Control request beats eligible data
    reset = 1'b1; enable = 1'b0;
    @(posedge clk);
    #1 isn = 32'd0; snmax = 32'd3; window = 16'd4; reset = 1'b0; enable = 1'b1; ctrl_req = 1'b1;
    push(32'd0, 1'b1);
    wait_send(20);
    ctrl_req = 1'b0;
    chk("ctrl_next_at_launch", next_seq, 32'd0);
    push(32'd0, 1'b0); push(32'd1, 1'b0); push(32'd2, 1'b0);
    do_tx(10);
    @(negedge clk);
    chk("ctrl_next_unchanged", next_seq, 32'd0);
    wait_send(20);
    t0 = cyc;
    do_tx(10);
    wait_send(20); do_tx(10);
    wait_send(20); do_tx(10);
    @(negedge clk);
    chk("edge_next_3", next_seq, 32'd3);

    // Future ACK beyond next_seq is dropped
    pulse_ack(32'd7);
    @(negedge clk);
    chk("future_ack_ignored", base, 32'd0);

    // ACK lands on the exact timeout cycle: ACK wins
    while (cyc < t0 + 100) begin
      @(posedge clk);
      #1;
    end
    ack_valid = 1'b1; ack_num = 32'd3;
    @(posedge clk);
    #1 ack_valid = 1'b0;
    @(negedge clk);
    chk("race_base", base, 32'd3);
    chk("race_next_seq", next_seq, 32'd3);
    chk("race_retx", 32'(retx_count), 32'd0);
    chk("race_all_acked", 32'(all_acked), 32'd1);
    repeat (10) @(negedge clk);
    chk("race_sb_empty", 32'(sb.size()), 32'd0);

    // Reset while a control packet is outstanding
    push(32'd3, 1'b1);
    ctrl_req = 1'b1;
    wait_send(20);
    ctrl_req = 1'b0;
    @(negedge clk);
    chk("mid_wait_tx", 32'(state), 32'd3);
    reset = 1'b1; enable = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_reset_vals();
    chk("final_sb_empty", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
